// File: rtl/i2c_target_regfile.sv
// I2C target with an internal 8-bit register bank. SCL/SDA are oversampled on CLK_SYS,
// glitch filtered, and decoded into pointer writes, burst writes and burst reads.
module i2c_target_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h39,
  parameter int         ADDR_WIDTH = 8,
  parameter int         FILTER_LEN = 3
) (
  input  logic                  CLK_SYS,
  input  logic                  RST,
  input  logic                  SCL_IN,
  input  logic                  SDA_IN,
  output logic                  SDA_OE,
  output logic                  wr_strobe,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [7:0]            dbg_data,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK = 4'd2;
  localparam logic [3:0] ST_PTR      = 4'd3;
  localparam logic [3:0] ST_WR_DATA  = 4'd4;
  localparam logic [3:0] ST_WR_ACK   = 4'd5;
  localparam logic [3:0] ST_RD_DATA  = 4'd6;
  localparam logic [3:0] ST_RD_ACK   = 4'd7;
  localparam logic [3:0] ST_IGNORE   = 4'd8;

  // Bit 0 carries SCL, bit 1 carries SDA through the conditioning pipeline.
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       filt;
  logic [1:0]       filt_d;
  logic [CNT_W-1:0] flt_cnt [2];

  logic [3:0]            state;
  logic [3:0]            bit_cnt;
  logic [7:0]            shreg;
  logic [7:0]            rx_byte;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  rw;
  logic                  ack_phase;
  logic [7:0]            regs [DEPTH];

  logic scl_rise;
  logic scl_fall;
  logic start_cond;
  logic stop_cond;

  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_d <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      sync1  <= {SDA_IN, SCL_IN};
      sync2  <= sync1;
      filt_d <= filt;
      // A level only propagates after FILTER_LEN consecutive disagreeing samples.
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CNT_LAST) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_rise   = filt[0] & ~filt_d[0];
  assign scl_fall   = ~filt[0] & filt_d[0];
  assign start_cond = ~filt[1] & filt_d[1] & filt[0];
  assign stop_cond  = filt[1] & ~filt_d[1] & filt[0];
  assign rx_byte    = {shreg[6:0], filt[1]};
  assign dbg_data   = regs[dbg_addr];

  always_ff @(posedge CLK_SYS) begin
    wr_strobe <= 1'b0;
    if (RST) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      SDA_OE    <= 1'b0;
      busy      <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else if (start_cond) begin
      state     <= ST_ADDR;
      bit_cnt   <= '0;
      ack_phase <= 1'b0;
      SDA_OE    <= 1'b0;
    end else if (stop_cond) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      SDA_OE    <= 1'b0;
      ack_phase <= 1'b0;
    end else begin
      case (state)
        // Receive states commit a byte only on its 8th rising edge, so cut-short bytes vanish.
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) begin
              bit_cnt   <= '0;
              ack_phase <= 1'b0;
              if (state == ST_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  busy  <= 1'b1;
                  rw    <= rx_byte[0];
                  state <= ST_ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= ST_IGNORE;
                end
              end else if (state == ST_PTR) begin
                ptr   <= ADDR_WIDTH'(rx_byte);
                state <= ST_WR_ACK;
              end else begin
                regs[ptr] <= rx_byte;
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr + 1'b1;
                state     <= ST_WR_ACK;
              end
            end
          end
        end
        // First falling edge pulls SDA low for the ACK, the second one releases it.
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              SDA_OE    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              if (state == ST_ADDR_ACK && rw) begin
                SDA_OE <= ~regs[ptr][7];
                shreg  <= {regs[ptr][6:0], 1'b0};
                state  <= ST_RD_DATA;
              end else begin
                SDA_OE <= 1'b0;
                state  <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WR_DATA;
              end
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              SDA_OE    <= 1'b0;
              ptr       <= ptr + 1'b1;
              ack_phase <= 1'b0;
              state     <= ST_RD_ACK;
            end else begin
              SDA_OE <= ~shreg[7];
              shreg  <= {shreg[6:0], 1'b0};
            end
          end
        end
        // ack_phase remembers that the master acknowledged and wants another byte.
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (filt[1]) begin
              busy   <= 1'b0;
              SDA_OE <= 1'b0;
              state  <= ST_IGNORE;
            end else begin
              ack_phase <= 1'b1;
            end
          end else if (scl_fall && ack_phase) begin
            ack_phase <= 1'b0;
            bit_cnt   <= '0;
            SDA_OE    <= ~regs[ptr][7];
            shreg     <= {regs[ptr][6:0], 1'b0};
            state     <= ST_RD_DATA;
          end
        end
        ST_IGNORE: SDA_OE <= 1'b0;
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
